// File: rtl/instruction_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_loader_if                                                    |
// | Byte-stream input, instruction-memory write port and datapath status.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface instruction_loader_if #(
  parameter int NBITS = 32
);
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic             i_start;
  logic             o_we;
  logic [NBITS-1:0] o_waddr;
  logic [NBITS-1:0] o_wdata;
  logic             o_cpu_rst;
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [NBITS-1:0] o_word_count;

  modport master (
    input  i_rx_data, i_rx_valid, i_start,
    output o_we, o_waddr, o_wdata, o_cpu_rst, o_busy, o_done, o_error, o_word_count
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_start,
    input  o_we, o_waddr, o_wdata, o_cpu_rst, o_busy, o_done, o_error, o_word_count
  );
endinterface
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_loader                                                       |
// | Packs a received byte stream into 32-bit words, writes them into the     |
// | instruction memory and holds the datapath in reset until the program is  |
// | complete. Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instruction_loader #(
  parameter int               NBITS     = 32,
  parameter int               MEM_SIZE  = 1024,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst,
  instruction_loader_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd2;
`endif
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [NBITS-1:0] C_LAST_ADDR = NBITS'(MEM_SIZE - 1);

  logic [2:0]       r_state;
  logic [1:0]       r_idx;
  logic [NBITS-9:0] r_shift;
  logic             r_we;
  logic [NBITS-1:0] r_waddr;
  logic [NBITS-1:0] r_wdata;
  logic [NBITS-1:0] r_word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic [NBITS-1:0] w_word;
  assign w_word = {r_shift, bus.i_rx_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_shift      <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.i_start) begin
            r_state      <= S_RECV;
            r_idx        <= 2'd0;
            r_waddr      <= '0;
            r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
          end
        end
        S_RECV: begin
          if (bus.i_rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ bus.i_rx_data;
`endif
            if (r_idx == 2'd3) begin
              // Index wraps in the same cycle so a back-to-back byte starts the next word.
              r_idx        <= 2'd0;
              r_we         <= 1'b1;
              r_wdata      <= w_word;
              r_waddr      <= r_word_count;
              r_word_count <= r_word_count + 1'b1;
              if (w_word == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_state <= S_DONE;
`endif
              end else if (r_word_count == C_LAST_ADDR) begin
                r_state <= S_ERROR;
              end
            end else begin
              r_shift <= {r_shift[NBITS-17:0], bus.i_rx_data};
              r_idx   <= r_idx + 2'd1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (bus.i_rx_valid) begin
            r_state <= (bus.i_rx_data == r_csum) ? S_DONE : S_ERROR;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_we         = r_we;
  assign bus.o_waddr      = r_waddr;
  assign bus.o_wdata      = r_wdata;
  assign bus.o_word_count = r_word_count;
  assign bus.o_done       = (r_state == S_DONE);
  assign bus.o_error      = (r_state == S_ERROR);
  assign bus.o_cpu_rst    = (r_state != S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign bus.o_busy       = (r_state == S_RECV) || (r_state == S_CHECK);
`else
  assign bus.o_busy       = (r_state == S_RECV);
`endif

endmodule
`default_nettype wire
